// File: rtl/nes_joypad_ps2.sv
// Purpose: PS/2 set-2 keyboard bytes -> NES controller button state for up to two pads,
//          served to the CPU through the standard strobe/shift serial protocol.
// Latency: pad_state changes one clk after the completing ps2_valid; dout follows the
//          shift register, so a read pulse shows its new bit on the next clk.
// Backpressure: none; every ps2_valid byte and every rd pulse is consumed in its own clk.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset_n    asynchronous active-low reset
//   ps2_data   received PS/2 byte, qualified by ps2_valid (one-clk pulse)
//   strobe     level of $4016 bit0 as last written by the CPU
//   rd         one-clk pulse per CPU read of each pad's port ($4016 / $4017)
//   dout       serial data bit per pad (D0 of the port read)
//   pad_state  live, opposite-masked buttons; byte p = pad p
//              bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
module nes_joypad_ps2 #(
  parameter int NUM_PADS       = 2,
  parameter int TIMEOUT        = 1000000,
  parameter bit ALLOW_OPPOSITE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_valid,
  input  logic                  strobe,
  input  logic [NUM_PADS-1:0]   rd,
  output logic [NUM_PADS-1:0]   dout,
  output logic [8*NUM_PADS-1:0] pad_state
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Button bit positions inside a pad byte.
  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  // Decoder state.
  logic          ext_flag;
  logic          brk_flag;
  logic [CW-1:0] idle_cnt;

  // Raw button storage is always two pads wide; with a single pad the second byte
  // is never written and stays zero, which keeps the key indexing simple.
  logic [1:0][7:0] raw_btn;
  logic [1:0][7:0] masked_btn;

  // Per-pad serial shift registers.
  logic [NUM_PADS-1:0][7:0] sr;

  // Key lookup result for the byte currently on ps2_data.
  logic       key_hit;
  logic       key_pad;
  logic [2:0] key_bit;

  // ---------------------------------------------------------------------------
  // Key map. The extended prefix selects a disjoint table: pad-1 codes are only
  // recognised without E0, the arrow keys only with it.
  // ---------------------------------------------------------------------------
  always_comb begin
    key_hit = 1'b0;
    key_pad = 1'b0;
    key_bit = BTN_A;
    if (ext_flag) begin
      case (ps2_data)
        8'h75: begin key_hit = 1'b1; key_bit = BTN_UP;    end
        8'h72: begin key_hit = 1'b1; key_bit = BTN_DOWN;  end
        8'h6B: begin key_hit = 1'b1; key_bit = BTN_LEFT;  end
        8'h74: begin key_hit = 1'b1; key_bit = BTN_RIGHT; end
        default: ;
      endcase
    end else begin
      case (ps2_data)
        // pad 0: Z X C V
        8'h1A: begin key_hit = 1'b1; key_bit = BTN_A;      end
        8'h22: begin key_hit = 1'b1; key_bit = BTN_B;      end
        8'h21: begin key_hit = 1'b1; key_bit = BTN_SELECT; end
        8'h2A: begin key_hit = 1'b1; key_bit = BTN_START;  end
        // pad 1: K L U I for buttons, W S A D for directions
        8'h42: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_A;      end
        8'h4B: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_B;      end
        8'h3C: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_SELECT; end
        8'h43: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_START;  end
        8'h1D: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_UP;     end
        8'h1B: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_DOWN;   end
        8'h1C: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_LEFT;   end
        8'h23: if (NUM_PADS == 2) begin key_hit = 1'b1; key_pad = 1'b1; key_bit = BTN_RIGHT;  end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Make/break decoder. Prefix bytes only set flags, so E0 F0 and F0 E0 land in
  // the same state. Any non-prefix byte (mapped, unmapped or E1) ends the code
  // and clears both flags. A prefix left dangling for TIMEOUT idle clks is
  // dropped so a lost byte cannot corrupt the next key.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      idle_cnt <= '0;
      raw_btn  <= '0;
    end else if (ps2_valid) begin
      idle_cnt <= '0;
      if (ps2_data == CODE_EXT) begin
        ext_flag <= 1'b1;
      end else if (ps2_data == CODE_BRK) begin
        brk_flag <= 1'b1;
      end else begin
        if (key_hit) begin
          raw_btn[key_pad][key_bit] <= !brk_flag;
        end
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + CW'(1);
    end else begin
      // Saturated: any pending prefix is stale. Buttons are left untouched.
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Opposite-direction masking sits after the raw register so that releasing
  // one key of a pair immediately restores the other; both pad_state and the
  // serial path see the masked view.
  // ---------------------------------------------------------------------------
  always_comb begin
    masked_btn = raw_btn;
    if (!ALLOW_OPPOSITE) begin
      for (int p = 0; p < 2; p++) begin
        if (raw_btn[p][BTN_UP] && raw_btn[p][BTN_DOWN]) begin
          masked_btn[p][BTN_UP]   = 1'b0;
          masked_btn[p][BTN_DOWN] = 1'b0;
        end
        if (raw_btn[p][BTN_LEFT] && raw_btn[p][BTN_RIGHT]) begin
          masked_btn[p][BTN_LEFT]  = 1'b0;
          masked_btn[p][BTN_RIGHT] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serial path. While strobe is high the register reloads every clk, so the
  // byte captured is the one present on the last clk before strobe falls, and
  // a read that coincides with strobe is a reload, not a shift. Shifting in 1s
  // makes a stock controller's "1 after 8 reads" fall out naturally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (strobe) begin
          sr[p] <= masked_btn[p];
        end else if (rd[p]) begin
          sr[p] <= {1'b1, sr[p][7:1]};
        end
      end
    end
  end

  always_comb begin
    dout      = '0;
    pad_state = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      dout[p]            = sr[p][0];
      pad_state[8*p +: 8] = masked_btn[p];
    end
  end

endmodule

// File: tb/tb_nes_joypad_ps2.sv
// Purpose: directed self-checking bench for nes_joypad_ps2 (two pads, short timeout);
//          a second instance with opposite directions allowed runs on the same inputs.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there as well.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_nes_joypad_ps2;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ps2_data;
  logic        ps2_valid;
  logic        strobe;
  logic [1:0]  rd;
  logic [1:0]  dout;
  logic [15:0] pad_state;
  logic [1:0]  dout_ao;
  logic [15:0] pad_state_ao;

  always #5 clk = ~clk;

  nes_joypad_ps2 #(.NUM_PADS(2), .TIMEOUT(TO), .ALLOW_OPPOSITE(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_data  (ps2_data),
    .ps2_valid (ps2_valid),
    .strobe    (strobe),
    .rd        (rd),
    .dout      (dout),
    .pad_state (pad_state)
  );

  nes_joypad_ps2 #(.NUM_PADS(2), .TIMEOUT(TO), .ALLOW_OPPOSITE(1'b1)) dut_ao (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_data  (ps2_data),
    .ps2_valid (ps2_valid),
    .strobe    (strobe),
    .rd        (rd),
    .dout      (dout_ao),
    .pad_state (pad_state_ao)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expectation is queued as the stimulus is issued, popped when
  // the DUT output is sampled.
  logic [15:0] exp_q[$];
  string       tag_q[$];

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_obs(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(posedge clk);
    #1;
    ps2_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [1:0] m);
    @(posedge clk);
    #1;
    rd = m;
    @(posedge clk);
    #1;
    rd = 2'b00;
  endtask

  initial begin
    logic [7:0] m0;
    logic [7:0] m1;

    reset_n   = 1'b0;
    ps2_data  = 8'h00;
    ps2_valid = 1'b0;
    strobe    = 1'b0;
    rd        = 2'b00;

    // Reset holds everything at zero even with traffic on the PS/2 side.
    send(8'h1A);
    send(8'h1A);
    send(8'h1A);
    expect_val("rst_pad", 16'h0000);    check_obs(pad_state);
    expect_val("rst_dout", 16'h0000);   check_obs({14'b0, dout});
    expect_val("rst_pad_ao", 16'h0000); check_obs(pad_state_ao);

    reset_n = 1'b1;
    tick(2);
    send(8'h1A);
    expect_val("make_z", 16'h0001); check_obs(pad_state);

    // Extended make/break, both prefix orders, and plain 75 ignored.
    send(8'hE0); send(8'h75);
    expect_val("ext_up_make", 16'h0011); check_obs(pad_state);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_val("ext_up_break", 16'h0001); check_obs(pad_state);
    send(8'h75);
    expect_val("plain_75", 16'h0001); check_obs(pad_state);
    send(8'hE0); send(8'h74);
    expect_val("ext_right_make", 16'h0081); check_obs(pad_state);
    send(8'hF0); send(8'hE0); send(8'h74);
    expect_val("f0e0_break", 16'h0001); check_obs(pad_state);
    send(8'hE0); send(8'hE1); send(8'h75);
    expect_val("e1_clears_ext", 16'h0001); check_obs(pad_state);
    send(8'hE0); send(8'h42);
    expect_val("ext_pad1_unmapped", 16'h0001); check_obs(pad_state);

    // Build pad0 = Z,V,Right = 0x89 and pad1 = K (A).
    send(8'h2A);
    send(8'hE0); send(8'h74);
    send(8'h42);
    expect_val("serial_setup", 16'h0189); check_obs(pad_state);

    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(1);
    m0 = 8'h89;
    m1 = 8'h01;
    for (int i = 0; i < 10; i++) begin
      expect_val($sformatf("ser0_%0d", i), {15'b0, m0[0]}); check_obs({15'b0, dout[0]});
      expect_val($sformatf("ser1_%0d", i), {15'b0, m1[0]}); check_obs({15'b0, dout[1]});
      if (i == 4) begin
        // Key event mid-read: live state moves, shift register does not.
        send(8'h21);
        expect_val("midread_pad", 16'h018D); check_obs(pad_state);
      end
      pulse_rd(2'b01);
      m0 = {1'b1, m0[7:1]};
    end

    // Back to pad0 = 0x01 only, then strobe priority over rd.
    send(8'hF0); send(8'h2A);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h21);
    send(8'hF0); send(8'h42);
    expect_val("prio_setup", 16'h0001); check_obs(pad_state);
    strobe = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      pulse_rd(2'b01);
      expect_val($sformatf("prio_rd_%0d", k), 16'h0001); check_obs({15'b0, dout[0]});
    end
    send(8'h22);
    send(8'hF0); send(8'h1A);
    expect_val("prio_pad_02", 16'h0002); check_obs(pad_state);
    expect_val("prio_dout_old", 16'h0001); check_obs({15'b0, dout[0]});
    tick(1);
    expect_val("prio_dout_new", 16'h0000); check_obs({15'b0, dout[0]});
    strobe = 1'b0;
    tick(1);

    // Opposite-direction masking on pad 1.
    send(8'hF0); send(8'h22);
    send(8'h1D); send(8'h1B);
    expect_val("opp_ws", 16'h0000);    check_obs(pad_state);
    expect_val("opp_ws_ao", 16'h3000); check_obs(pad_state_ao);
    send(8'hF0); send(8'h1B);
    expect_val("opp_w", 16'h1000);    check_obs(pad_state);
    expect_val("opp_w_ao", 16'h1000); check_obs(pad_state_ao);
    send(8'hF0); send(8'h1D);
    send(8'h1C); send(8'h23);
    expect_val("opp_ad", 16'h0000);    check_obs(pad_state);
    expect_val("opp_ad_ao", 16'hC000); check_obs(pad_state_ao);
    // Masked view also feeds the serial path: Left+Right read as 0 on bits 6,7.
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(1);
    m1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pulse_rd(2'b10);
      m1 = {1'b1, m1[7:1]};
    end
    expect_val("opp_serial_done", 16'h0001); check_obs({15'b0, dout[1]});
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) pulse_rd(2'b10);
    expect_val("opp_serial_b6", 16'h0000);    check_obs({15'b0, dout[1]});
    expect_val("opp_serial_b6_ao", 16'h0001); check_obs({15'b0, dout_ao[1]});
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h23);
    expect_val("opp_clear", 16'h0000); check_obs(pad_state);

    // Timeout of a pending prefix.
    send(8'hE0);
    tick(TO + 10);
    send(8'h75);
    expect_val("to_ext_dropped", 16'h0000); check_obs(pad_state);
    send(8'hF0);
    tick(TO + 10);
    send(8'h1A);
    expect_val("to_brk_dropped", 16'h0001); check_obs(pad_state);
    send(8'hE0);
    tick(10);
    send(8'h75);
    expect_val("to_short_idle", 16'h0011); check_obs(pad_state);

    // Reset in the middle of a read sequence.
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    pulse_rd(2'b01);
    reset_n = 1'b0;
    #2;
    expect_val("midrst_pad", 16'h0000);  check_obs(pad_state);
    expect_val("midrst_dout", 16'h0000); check_obs({14'b0, dout});
    tick(1);
    reset_n = 1'b1;
    tick(2);
    expect_val("postrst_pad", 16'h0000); check_obs(pad_state);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
